mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Load/store sequencer between the pipeline MEM stage and the data-memory bus.
- Per request: checks address alignment for the access size (2^N-alignment rule, N = 0/1/2 for byte/half/word), then either reports an address-error exception or runs one bus transaction.
- Generates byte enables, replicates store data, and extracts and extends load data.
- Returns exactly one response per accepted request, using valid/ready handshakes on both request and response sides.

Parameters:
- WIDTH, 32, address/data width; only 32 is supported (byte-lane logic is fixed at 4 lanes).
- EXC_ADEL, 4, exception code for a misaligned load or a reserved size on a load.
- EXC_ADES, 5, exception code for a misaligned store or a reserved size on a store.
- EXC_DBE, 7, exception code for a bus timeout (used only with the optional feature).
- MAX_WAIT, 16, bus-wait cycle limit before timeout (optional feature only).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer takes the response.
- resp_rdata  out  32  extended load data; 0 for stores and for exceptions.
- resp_exc  out  1  response is an exception.
- resp_exc_code  out  5  exception code; 0 when resp_exc = 0.
- bad_vaddr  out  32  faulting address; holds its value until the next exception.
- mem_en  out  1  bus request.
- mem_we  out  4  byte write enables; 0000 on loads.
- mem_addr  out  32  {addr[31:2], 2'b00}.
- mem_wdata  out  32  lane-replicated store data.
- mem_ack  in  1  bus completes this cycle.
- mem_rdata  in  32  read word, valid when mem_ack = 1.

Behaviour:
- States: IDLE, BUS, RESP. All outputs are registered or decoded from state plus latched request.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_exc=0, resp_exc_code=0, resp_rdata=0, bad_vaddr=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- IDLE:
  - req_ready=1.
  - On req_valid, latch all request fields.
  - Aligned condition: low N bits of addr are zero (N = 0/1/2 for byte/half/word).
  - Size 11 is always an exception.
  - Aligned request → go to BUS.
  - Otherwise → go to RESP with resp_exc=1, code EXC_ADES if write else EXC_ADEL, and bad_vaddr=req_addr. No bus activity occurs.
- BUS:
  - mem_en=1; mem_addr, mem_we and mem_wdata held stable until mem_ack.
  - Byte enables: byte = 0001<<addr[1:0]; half = 0011<<addr[1:0]; word = 1111. mem_we is 0000 on loads.
  - Store data: byte = {4{wdata[7:0]}}, half = {2{wdata[15:0]}}, word = wdata.
  - On mem_ack, capture data: shift mem_rdata right by 8*addr[1:0], take the low 8/16/32 bits, then sign- or zero-extend per req_signed. Store responses carry rdata=0.
  - Go to RESP.
- RESP:
  - resp_valid=1; outputs held until resp_ready, then go to IDLE.
  - req_ready=0 in BUS and RESP; there is no request overlap.
- mem_ack outside BUS is ignored.
- Latency:
  - Exception: accepted at edge T, resp_valid from T+1.
  - Bus access with ack in the first BUS cycle: mem_en high in cycle T+1, resp_valid from T+2.
- resp_ready held high with a continuous request stream gives one request per 3 cycles for bus accesses and one per 2 for exceptions.
- Reset asserted in any state: the next edge forces IDLE and the reset values, drops mem_en, and discards any pending response.

Optional Feature:
- Macro: MEM_ACCESS_CTRL_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to BUS and increments each BUS cycle without mem_ack.
  - When the count reaches MAX_WAIT, drop mem_en, go to RESP with resp_exc=1, code EXC_DBE, and bad_vaddr=latched addr.
  - mem_ack in the same cycle as the limit wins, and the access completes normally.
- Undefined: no counter; BUS waits indefinitely.

Test Plan:
- Load word, addr 0x1000, signed=0, mem_ack after 2 wait cycles with rdata 0x80FF_1234 → mem_addr=0x1000, mem_we=0000, response rdata=0x80FF1234, resp_exc=0.
- Load byte signed, addr 0x1003, rdata 0x80FF1234 → mem_we=0000, rdata=0xFFFFFF80. Same with signed=0 → 0x00000080. Load half signed, addr 0x1002 → 0xFFFF80FF.
- Store half, addr 0x2002, wdata 0xDEADBEEF → mem_we=1100, mem_wdata=0xBEEFBEEF, mem_addr=0x2000.
- Store word, addr 0x2001 → no mem_en, resp_exc=1, code 5, bad_vaddr=0x2001. Load with size 11, addr 0x0 → code 4.
- Response with resp_ready held low for 5 cycles → outputs stable and req_ready=0 throughout. Reset asserted during BUS → mem_en=0 and resp_valid=0 after the edge.
- TIMEOUT_EN, MAX_WAIT=16, no ack → code 7 after 16 BUS cycles. Ack in cycle 16 → normal completion.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// ----------------------------------------------------------------------------
// mem_access_ctrl_if
// Groups the three handshake/bus sides of the load/store sequencer:
//   request  : req_valid, req_ready, req_write, req_size, req_signed,
//              req_addr, req_wdata
//   response : resp_valid, resp_ready, resp_rdata, resp_exc, resp_exc_code,
//              bad_vaddr
//   data bus : mem_en, mem_we, mem_addr, mem_wdata, mem_ack, mem_rdata
// Modports:
//   slave  - the controller's view (takes requests, drives response and bus)
//   master - the environment's view (pipeline MEM stage plus memory)
// ----------------------------------------------------------------------------
interface mem_access_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic             req_write;
  logic [1:0]       req_size;
  logic             req_signed;
  logic [WIDTH-1:0] req_addr;
  logic [WIDTH-1:0] req_wdata;

  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_rdata;
  logic             resp_exc;
  logic [4:0]       resp_exc_code;
  logic [WIDTH-1:0] bad_vaddr;

  logic             mem_en;
  logic [3:0]       mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_ack;
  logic [WIDTH-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  resp_ready, mem_ack, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_exc, resp_exc_code,
    output bad_vaddr, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output resp_ready, mem_ack, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_exc, resp_exc_code,
    input  bad_vaddr, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// ----------------------------------------------------------------------------
// mem_access_ctrl
// Load/store sequencer between the MEM stage and the data-memory bus.
// Each accepted request is alignment-checked; a misaligned or reserved-size
// request answers with an address-error exception, otherwise one bus
// transaction runs (byte enables, lane-replicated store data, shifted and
// extended load data). Exactly one response per request.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-high reset
//   bus   - mem_access_ctrl_if.slave (request, response and memory bus)
// Optional feature macro: MEM_ACCESS_CTRL_TIMEOUT_EN
//   When defined, a BUS wait of MAX_WAIT cycles without mem_ack ends the
//   access with exception EXC_DBE. When undefined, BUS waits indefinitely.
// ----------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int WIDTH    = 32,
  parameter int EXC_ADEL = 4,
  parameter int EXC_ADES = 5,
  parameter int EXC_DBE  = 7,
  parameter int MAX_WAIT = 16
) (
  input  logic             clk,
  input  logic             reset,
  mem_access_ctrl_if.slave bus
);

  // Byte-lane logic is hard-wired for four lanes; refuse anything else.
  if (WIDTH != 32 || EXC_ADEL > 31 || EXC_ADES > 31 || EXC_DBE > 31 || MAX_WAIT < 1)
  begin : g_cfg_check
    $error("mem_access_ctrl: unsupported parameter set");
  end

  localparam logic [4:0] ADEL_C = 5'(EXC_ADEL);
  localparam logic [4:0] ADES_C = 5'(EXC_ADES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e state_q, state_d;

  // latched request fields
  logic             write_q, write_d;
  logic [1:0]       size_q, size_d;
  logic             signed_q, signed_d;
  logic [1:0]       addr_lo_q, addr_lo_d;

  // registered outputs
  logic             req_ready_q, req_ready_d;
  logic             resp_valid_q, resp_valid_d;
  logic [WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic             resp_exc_q, resp_exc_d;
  logic [4:0]       resp_exc_code_q, resp_exc_code_d;
  logic [WIDTH-1:0] bad_vaddr_q, bad_vaddr_d;
  logic             mem_en_q, mem_en_d;
  logic [3:0]       mem_we_q, mem_we_d;
  logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  logic             aligned_s;
  logic [3:0]       be_s;
  logic [WIDTH-1:0] wdata_rep_s;
  logic [WIDTH-1:0] load_shift_s;
  logic [WIDTH-1:0] load_ext_s;
  logic             timeout_s;

`ifdef MEM_ACCESS_CTRL_TIMEOUT_EN
  localparam int         CNT_W     = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  // Timeout fires at the end of the MAX_WAIT-th ack-less BUS cycle; an ack
  // in that same cycle takes priority.
  assign timeout_s = (state_q == BUS) && !bus.mem_ack && (wait_cnt_q == WAIT_LAST);

  // Wait counter next value: clear on BUS entry, count ack-less BUS cycles.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q != BUS) begin
      wait_cnt_d = '0;
    end else if (!bus.mem_ack) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
  end

  // Wait counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // Request decode: alignment, byte enables and store-lane replication.
  always_comb begin
    aligned_s   = 1'b0;
    be_s        = 4'b1111;
    wdata_rep_s = bus.req_wdata;
    case (bus.req_size)
      2'b00: begin
        aligned_s   = 1'b1;
        be_s        = 4'b0001 << bus.req_addr[1:0];
        wdata_rep_s = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        aligned_s   = (bus.req_addr[0] == 1'b0);
        be_s        = 4'b0011 << bus.req_addr[1:0];
        wdata_rep_s = {2{bus.req_wdata[15:0]}};
      end
      2'b10: begin
        aligned_s   = (bus.req_addr[1:0] == 2'b00);
        be_s        = 4'b1111;
        wdata_rep_s = bus.req_wdata;
      end
      default: begin
        aligned_s   = 1'b0;
        be_s        = 4'b0000;
        wdata_rep_s = bus.req_wdata;
      end
    endcase
  end

  assign load_shift_s = bus.mem_rdata >> {addr_lo_q, 3'b000};

  // Load data extraction and sign/zero extension from the shifted word.
  always_comb begin
    load_ext_s = load_shift_s;
    case (size_q)
      2'b00: begin
        if (signed_q) begin
          load_ext_s = {{24{load_shift_s[7]}}, load_shift_s[7:0]};
        end else begin
          load_ext_s = {24'd0, load_shift_s[7:0]};
        end
      end
      2'b01: begin
        if (signed_q) begin
          load_ext_s = {{16{load_shift_s[15]}}, load_shift_s[15:0]};
        end else begin
          load_ext_s = {16'd0, load_shift_s[15:0]};
        end
      end
      default: load_ext_s = load_shift_s;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          state_d = aligned_s ? BUS : RESP;
        end else begin
          state_d = IDLE;
        end
      end
      BUS: begin
        if (bus.mem_ack || timeout_s) begin
          state_d = RESP;
        end else begin
          state_d = BUS;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values; handshake flags follow the next state so
  // they are registered in step with it.
  always_comb begin
    write_d         = write_q;
    size_d          = size_q;
    signed_d        = signed_q;
    addr_lo_d       = addr_lo_q;
    resp_rdata_d    = resp_rdata_q;
    resp_exc_d      = resp_exc_q;
    resp_exc_code_d = resp_exc_code_q;
    bad_vaddr_d     = bad_vaddr_q;
    mem_we_d        = mem_we_q;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    req_ready_d     = (state_d == IDLE);
    resp_valid_d    = (state_d == RESP);
    mem_en_d        = (state_d == BUS);
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          write_d   = bus.req_write;
          size_d    = bus.req_size;
          signed_d  = bus.req_signed;
          addr_lo_d = bus.req_addr[1:0];
          if (aligned_s) begin
            mem_addr_d  = {bus.req_addr[WIDTH-1:2], 2'b00};
            mem_we_d    = bus.req_write ? be_s : 4'b0000;
            mem_wdata_d = wdata_rep_s;
          end else begin
            resp_rdata_d    = '0;
            resp_exc_d      = 1'b1;
            resp_exc_code_d = bus.req_write ? ADES_C : ADEL_C;
            bad_vaddr_d     = bus.req_addr;
          end
        end else begin
          write_d = write_q;
        end
      end
      BUS: begin
        if (bus.mem_ack) begin
          resp_rdata_d    = write_q ? '0 : load_ext_s;
          resp_exc_d      = 1'b0;
          resp_exc_code_d = 5'd0;
        end else if (timeout_s) begin
          resp_rdata_d    = '0;
          resp_exc_d      = 1'b1;
`ifdef MEM_ACCESS_CTRL_TIMEOUT_EN
          resp_exc_code_d = 5'(EXC_DBE);
`else
          resp_exc_code_d = resp_exc_code_q;
`endif
          bad_vaddr_d     = {mem_addr_q[WIDTH-1:2], addr_lo_q};
        end else begin
          resp_rdata_d = resp_rdata_q;
        end
      end
      default: begin
        resp_rdata_d = resp_rdata_q;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latched request and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      write_q         <= 1'b0;
      size_q          <= 2'b00;
      signed_q        <= 1'b0;
      addr_lo_q       <= 2'b00;
      req_ready_q     <= 1'b1;
      resp_valid_q    <= 1'b0;
      resp_rdata_q    <= '0;
      resp_exc_q      <= 1'b0;
      resp_exc_code_q <= 5'd0;
      bad_vaddr_q     <= '0;
      mem_en_q        <= 1'b0;
      mem_we_q        <= 4'b0000;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
    end else begin
      write_q         <= write_d;
      size_q          <= size_d;
      signed_q        <= signed_d;
      addr_lo_q       <= addr_lo_d;
      req_ready_q     <= req_ready_d;
      resp_valid_q    <= resp_valid_d;
      resp_rdata_q    <= resp_rdata_d;
      resp_exc_q      <= resp_exc_d;
      resp_exc_code_q <= resp_exc_code_d;
      bad_vaddr_q     <= bad_vaddr_d;
      mem_en_q        <= mem_en_d;
      mem_we_q        <= mem_we_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
    end
  end

  assign bus.req_ready     = req_ready_q;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_rdata    = resp_rdata_q;
  assign bus.resp_exc      = resp_exc_q;
  assign bus.resp_exc_code = resp_exc_code_q;
  assign bus.bad_vaddr     = bad_vaddr_q;
  assign bus.mem_en        = mem_en_q;
  assign bus.mem_we        = mem_we_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wdata     = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mem_access_ctrl
// Directed self-checking bench for mem_access_ctrl with hand-computed
// expected values. Timeout steps run only when MEM_ACCESS_CTRL_TIMEOUT_EN
// is defined.
// ----------------------------------------------------------------------------
module tb_mem_access_ctrl;

  logic clk;
  logic reset;
  int   compared;
  int   mismatched;

  mem_access_ctrl_if #(.WIDTH(32)) bus ();

  mem_access_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    tick();
    bus.req_valid  = 1'b0;
  endtask

  task automatic ack(input logic [31:0] rdata);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = rdata;
    tick();
    bus.mem_ack   = 1'b0;
  endtask

  task automatic take_resp(input string tag);
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    chk({tag, "_idle_ready"}, 32'(bus.req_ready), 32'd1);
    chk({tag, "_idle_valid"}, 32'(bus.resp_valid), 32'd0);
  endtask

  // Bus access acked in its first BUS cycle.
  task automatic bus_access(input string tag, input logic wr, input logic [1:0] sz,
                            input logic sg, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rdata,
                            input logic [31:0] exp_addr, input logic [3:0] exp_we,
                            input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
    do_req(wr, sz, sg, addr, wdata);
    chk({tag, "_mem_en"}, 32'(bus.mem_en), 32'd1);
    chk({tag, "_mem_addr"}, bus.mem_addr, exp_addr);
    chk({tag, "_mem_we"}, 32'(bus.mem_we), 32'(exp_we));
    if (wr) begin
      chk({tag, "_mem_wdata"}, bus.mem_wdata, exp_wdata);
    end else begin
      chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
    end
    ack(rdata);
    chk({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd1);
    chk({tag, "_rdata"}, bus.resp_rdata, exp_rdata);
    chk({tag, "_exc"}, 32'(bus.resp_exc), 32'd0);
    chk({tag, "_code"}, 32'(bus.resp_exc_code), 32'd0);
    chk({tag, "_mem_en_off"}, 32'(bus.mem_en), 32'd0);
    take_resp(tag);
  endtask

  // Request that must be rejected without bus activity.
  task automatic exc_req(input string tag, input logic wr, input logic [1:0] sz,
                         input logic [31:0] addr, input logic [4:0] exp_code);
    do_req(wr, sz, 1'b0, addr, 32'h1111_2222);
    chk({tag, "_mem_en"}, 32'(bus.mem_en), 32'd0);
    chk({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd1);
    chk({tag, "_exc"}, 32'(bus.resp_exc), 32'd1);
    chk({tag, "_code"}, 32'(bus.resp_exc_code), 32'(exp_code));
    chk({tag, "_bad_vaddr"}, bus.bad_vaddr, addr);
    chk({tag, "_rdata"}, bus.resp_rdata, 32'd0);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
    take_resp(tag);
  endtask

  initial begin
    compared       = 0;
    mismatched     = 0;
    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    bus.resp_ready = 1'b0;
    bus.mem_ack    = 1'b0;
    bus.mem_rdata  = 32'd0;
    tick();
    tick();
    reset = 1'b0;

    // Reset values
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_exc", 32'(bus.resp_exc), 32'd0);
    chk("rst_code", 32'(bus.resp_exc_code), 32'd0);
    chk("rst_rdata", bus.resp_rdata, 32'd0);
    chk("rst_bad_vaddr", bus.bad_vaddr, 32'd0);
    chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);

    // Load word with two wait cycles before ack
    do_req(1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'd0);
    chk("lw_mem_en", 32'(bus.mem_en), 32'd1);
    chk("lw_mem_addr", bus.mem_addr, 32'h0000_1000);
    chk("lw_mem_we", 32'(bus.mem_we), 32'd0);
    chk("lw_req_ready", 32'(bus.req_ready), 32'd0);
    tick();
    tick();
    chk("lw_wait_mem_en", 32'(bus.mem_en), 32'd1);
    chk("lw_wait_addr", bus.mem_addr, 32'h0000_1000);
    chk("lw_wait_valid", 32'(bus.resp_valid), 32'd0);
    ack(32'h80FF_1234);
    chk("lw_resp_valid", 32'(bus.resp_valid), 32'd1);
    chk("lw_rdata", bus.resp_rdata, 32'h80FF_1234);
    chk("lw_exc", 32'(bus.resp_exc), 32'd0);
    chk("lw_mem_en_off", 32'(bus.mem_en), 32'd0);
    take_resp("lw");

    // Sub-word loads
    bus_access("lb_s3", 1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'd0, 32'h80FF_1234,
               32'h0000_1000, 4'b0000, 32'd0, 32'hFFFF_FF80);
    bus_access("lbu_3", 1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'd0, 32'h80FF_1234,
               32'h0000_1000, 4'b0000, 32'd0, 32'h0000_0080);
    bus_access("lh_s2", 1'b0, 2'b01, 1'b1, 32'h0000_1002, 32'd0, 32'h80FF_1234,
               32'h0000_1000, 4'b0000, 32'd0, 32'hFFFF_80FF);
    bus_access("lhu_0", 1'b0, 2'b01, 1'b0, 32'h0000_1000, 32'd0, 32'h80FF_1234,
               32'h0000_1000, 4'b0000, 32'd0, 32'h0000_1234);
    bus_access("lb_s1", 1'b0, 2'b00, 1'b1, 32'h0000_1001, 32'd0, 32'h80FF_1234,
               32'h0000_1000, 4'b0000, 32'd0, 32'h0000_0012);

    // Stores; response data is zero regardless of mem_rdata
    bus_access("sh_2", 1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'hDEAD_BEEF, 32'hFFFF_FFFF,
               32'h0000_2000, 4'b1100, 32'hBEEF_BEEF, 32'd0);
    bus_access("sb_1", 1'b1, 2'b00, 1'b0, 32'h0000_2001, 32'h0000_00A5, 32'hFFFF_FFFF,
               32'h0000_2000, 4'b0010, 32'hA5A5_A5A5, 32'd0);
    bus_access("sw_4", 1'b1, 2'b10, 1'b0, 32'h0000_2004, 32'h1234_5678, 32'hFFFF_FFFF,
               32'h0000_2004, 4'b1111, 32'h1234_5678, 32'd0);

    // Address errors
    exc_req("sw_mis", 1'b1, 2'b10, 32'h0000_2001, 5'd5);
    exc_req("lres", 1'b0, 2'b11, 32'h0000_0000, 5'd4);
    exc_req("lh_mis", 1'b0, 2'b01, 32'h0000_3001, 5'd4);
    exc_req("sres", 1'b1, 2'b11, 32'h0000_4000, 5'd5);

    // bad_vaddr holds across a clean access
    bus_access("lw_after", 1'b0, 2'b10, 1'b0, 32'h0000_0008, 32'd0, 32'h0BAD_F00D,
               32'h0000_0008, 4'b0000, 32'd0, 32'h0BAD_F00D);
    chk("bad_vaddr_hold", bus.bad_vaddr, 32'h0000_4000);

    // Response stalled for 5 cycles; a stray mem_ack in RESP is ignored
    do_req(1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'd0);
    ack(32'hCAFE_F00D);
    for (int i = 0; i < 5; i++) begin
      bus.mem_ack   = (i == 2);
      bus.mem_rdata = 32'h0000_0000;
      tick();
      chk("stall_valid", 32'(bus.resp_valid), 32'd1);
      chk("stall_rdata", bus.resp_rdata, 32'hCAFE_F00D);
      chk("stall_req_ready", 32'(bus.req_ready), 32'd0);
      chk("stall_mem_en", 32'(bus.mem_en), 32'd0);
    end
    bus.mem_ack = 1'b0;
    take_resp("stall");

    // Reset during BUS
    do_req(1'b0, 2'b10, 1'b0, 32'h0000_5000, 32'd0);
    chk("rbus_mem_en", 32'(bus.mem_en), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rbus_mem_en_off", 32'(bus.mem_en), 32'd0);
    chk("rbus_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rbus_req_ready", 32'(bus.req_ready), 32'd1);

    // mem_ack while IDLE produces nothing
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    tick();
    chk("idle_ack_valid", 32'(bus.resp_valid), 32'd0);
    chk("idle_ack_mem_en", 32'(bus.mem_en), 32'd0);

`ifdef MEM_ACCESS_CTRL_TIMEOUT_EN
    // No ack: 16 BUS cycles, then bus error
    do_req(1'b0, 2'b10, 1'b0, 32'h0000_6004, 32'd0);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("to_wait_mem_en", 32'(bus.mem_en), 32'd1);
    end
    tick();
    chk("to_resp_valid", 32'(bus.resp_valid), 32'd1);
    chk("to_exc", 32'(bus.resp_exc), 32'd1);
    chk("to_code", 32'(bus.resp_exc_code), 32'd7);
    chk("to_bad_vaddr", bus.bad_vaddr, 32'h0000_6004);
    chk("to_mem_en", 32'(bus.mem_en), 32'd0);
    take_resp("to");

    // Ack in the 16th BUS cycle completes normally
    do_req(1'b0, 2'b01, 1'b1, 32'h0000_6002, 32'd0);
    for (int i = 0; i < 15; i++) begin
      tick();
    end
    chk("to16_mem_en", 32'(bus.mem_en), 32'd1);
    ack(32'h8001_0000);
    chk("to16_valid", 32'(bus.resp_valid), 32'd1);
    chk("to16_exc", 32'(bus.resp_exc), 32'd0);
    chk("to16_rdata", bus.resp_rdata, 32'hFFFF_8001);
    take_resp("to16");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
